sdio_host_cmd: RTL and testbench
================================

SDIO_HOST_CMD -- requirements
Module: sdio_host_cmd

Interface
REQ-001 SHALL have parameter PREAMBLE, default 16, meaning the number of '1' bits driven before each command start bit.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles after line release to wait for a response start bit.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; one CMD bit per cycle.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a command is offered.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a command.
REQ-007 SHALL have port req_cmd, input, 6 bits: the command index.
REQ-008 SHALL have port req_arg, input, 32 bits: the command argument.
REQ-009 SHALL have port cmd_o, output, 1 bit: CMD line drive value.
REQ-010 SHALL have port cmd_oe, output, 1 bit: CMD drive enable; the tristate buffer is external.
REQ-011 SHALL have port cmd_i, input, 1 bit: CMD line sample, already in the clk domain.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle pulse when a transaction completes.
REQ-013 SHALL have port resp_cmd, output, 6 bits: the received command index.
REQ-014 SHALL have port resp_arg, output, 32 bits: the received argument.
REQ-015 SHALL have port resp_status, output, 2 bits: 0 OK, 1 CRC error, 2 timeout, 3 framing error.

Function
REQ-016 SHALL implement states IDLE, PRE, TX, WAIT, RX and DONE.
REQ-017 SHALL drive req_ready=1 only in IDLE; the handshake is req_valid&&req_ready on a rising edge.
REQ-018 SHALL, on handshake, latch req_cmd/req_arg and enter PRE; req_valid outside IDLE SHALL be ignored.
REQ-019 SHALL, in PRE, hold cmd_oe=1 and cmd_o=1 for exactly PREAMBLE cycles, then enter TX.
REQ-020 SHALL, in TX, shift out 48 bits MSB first, one per cycle, with cmd_oe=1: start bit 0, transmission bit 1, cmd[5:0], arg[31:0], CRC7[6:0], end bit 1.
REQ-021 SHALL compute CRC7 with polynomial x^7+x^3+1 and zero initial value over the first 40 frame bits, serially during TX.
REQ-022 SHALL, on the cycle after the end bit, set cmd_oe=0 and enter WAIT with the timeout counter cleared.
REQ-023 SHALL, in WAIT, sample cmd_i each cycle; the first 0 is the response start bit, and the block SHALL then enter RX.
REQ-024 SHALL, if TIMEOUT cycles elapse in WAIT with no 0 sampled, enter DONE with status 2 and resp_cmd/resp_arg = 0.
REQ-025 SHALL, in RX, shift in the remaining 47 bits and run the receive CRC7 over bits 47..8.
REQ-026 SHALL, after the 48th bit, set status: 3 if the transmission bit is not 0 or the end bit is not 1; else 1 if the received CRC does not equal the computed CRC; else 0; framing error SHALL take precedence over CRC error.
REQ-027 SHALL, in DONE, pulse resp_valid for one cycle with resp_cmd/resp_arg/resp_status stable, then return to IDLE.
REQ-028 SHALL hold resp_cmd/resp_arg/resp_status until the next DONE.
REQ-029 SHALL produce a fixed timing from handshake edge to last TX bit of PREAMBLE+48 cycles.
REQ-030 SHALL make a new handshake possible on the cycle after resp_valid.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force state IDLE, req_ready=1, cmd_oe=0, cmd_o=1, resp_valid=0, resp_cmd=0, resp_arg=0, resp_status=0, and clear all counters and CRC registers.
REQ-032 SHALL, on reset asserted mid-transaction, release CMD immediately and emit no resp_valid for the aborted transaction.

Verification
REQ-033 Bench: cmd=0x3F, arg=0xF0000F0F -> after 16 ones, the TX bytes are 7F F0 00 0F 0F 0B; the device model replies 3F F0 0F F0 0F FB after a 2-cycle gap -> resp_valid with cmd=0x3F, arg=0xF00FF00F, status=0.
REQ-034 Bench: cmd=0x00, arg=0 -> TX bytes are 40 00 00 00 00 95.
REQ-035 Bench: the device stays high -> resp_valid exactly TIMEOUT cycles after release with status=2.
REQ-036 Bench: response as in REQ-033 with last byte FD (CRC 0x7E) -> status=1; with last byte FA (end bit 0) -> status=3.
REQ-037 Bench: req_valid held high continuously -> exactly one command per transaction with no overlap, and req_ready low from handshake until IDLE.
REQ-038 Bench: rst_n pulsed low during TX bit 20 -> cmd_oe=0 in the same cycle, no resp_valid, and the next command completes normally.

Source files
------------

// File: rtl/sdio_host_cmd.sv
// SDIO host command-line engine: sends a 48-bit command frame after a preamble,
// then waits for and receives a 48-bit response frame with CRC7 checking.
module sdio_host_cmd #(
    parameter int unsigned PREAMBLE = 16,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_cmd,
    input  logic [31:0] req_arg,
    output logic        cmd_o,
    output logic        cmd_oe,
    input  logic        cmd_i,
    output logic        resp_valid,
    output logic [5:0]  resp_cmd,
    output logic [31:0] resp_arg,
    output logic [1:0]  resp_status
);

    localparam int unsigned FRAME_BITS = 48;
    localparam int unsigned CRC_BITS   = 40;
    localparam int unsigned MAX_PT     = (PREAMBLE > TIMEOUT) ? PREAMBLE : TIMEOUT;
    localparam int unsigned CNT_MAX    = (MAX_PT > FRAME_BITS) ? MAX_PT : FRAME_BITS;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_CRC     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_FRAME   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TX,
        S_WAIT,
        S_RX,
        S_DONE
    } state_e;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [39:0]       tx_sh_q, tx_sh_d;
    logic [46:0]       rx_sh_q, rx_sh_d;
    logic [6:0]        crc_q, crc_d;
    logic              req_ready_q, req_ready_d;
    logic              cmd_o_q, cmd_o_d;
    logic              cmd_oe_q, cmd_oe_d;
    logic              resp_valid_q, resp_valid_d;
    logic [5:0]        resp_cmd_q, resp_cmd_d;
    logic [31:0]       resp_arg_q, resp_arg_d;
    logic [1:0]        resp_status_q, resp_status_d;

    assign req_ready   = req_ready_q;
    assign cmd_o       = cmd_o_q;
    assign cmd_oe      = cmd_oe_q;
    assign resp_valid  = resp_valid_q;
    assign resp_cmd    = resp_cmd_q;
    assign resp_arg    = resp_arg_q;
    assign resp_status = resp_status_q;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tx_sh_q       <= '0;
            rx_sh_q       <= '0;
            crc_q         <= '0;
            req_ready_q   <= 1'b1;
            cmd_o_q       <= 1'b1;
            cmd_oe_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_cmd_q    <= '0;
            resp_arg_q    <= '0;
            resp_status_q <= ST_OK;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            crc_q         <= crc_d;
            req_ready_q   <= req_ready_d;
            cmd_o_q       <= cmd_o_d;
            cmd_oe_q      <= cmd_oe_d;
            resp_valid_q  <= resp_valid_d;
            resp_cmd_q    <= resp_cmd_d;
            resp_arg_q    <= resp_arg_d;
            resp_status_q <= resp_status_d;
        end
    end

    // Next state; cmd_o_d is the bit the line carries in the coming cycle
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        crc_d         = crc_q;
        cmd_o_d       = 1'b1;
        cmd_oe_d      = 1'b0;
        resp_cmd_d    = resp_cmd_q;
        resp_arg_d    = resp_arg_q;
        resp_status_d = resp_status_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d  = S_PRE;
                    tx_sh_d  = {2'b01, req_cmd, req_arg};
                    cnt_d    = '0;
                    crc_d    = '0;
                    cmd_oe_d = 1'b1;
                end
            end
            S_PRE: begin
                cmd_oe_d = 1'b1;
                if (cnt_q == CNT_W'(PREAMBLE - 1)) begin
                    state_d = S_TX;
                    cnt_d   = '0;
                    cmd_o_d = tx_sh_q[39];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_TX: begin
                // cnt_q indexes the bit currently on the line
                cmd_oe_d = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q < CNT_W'(CRC_BITS - 1)) begin
                    crc_d   = crc7_step(crc_q, tx_sh_q[39]);
                    tx_sh_d = {tx_sh_q[38:0], 1'b0};
                    cmd_o_d = tx_sh_q[38];
                end else if (cnt_q == CNT_W'(CRC_BITS - 1)) begin
                    crc_d   = crc7_step(crc_q, tx_sh_q[39]);
                    cmd_o_d = crc_d[6];
                end else if (cnt_q < CNT_W'(FRAME_BITS - 2)) begin
                    crc_d   = {crc_q[5:0], 1'b0};
                    cmd_o_d = crc_q[5];
                end else if (cnt_q == CNT_W'(FRAME_BITS - 2)) begin
                    cmd_o_d = 1'b1;
                end else begin
                    state_d  = S_WAIT;
                    cnt_d    = '0;
                    cmd_oe_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (!cmd_i) begin
                    // Start bit is 0, so the CRC over it stays at the zero seed
                    state_d = S_RX;
                    cnt_d   = CNT_W'(1);
                    crc_d   = '0;
                    rx_sh_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = S_DONE;
                    resp_cmd_d    = '0;
                    resp_arg_d    = '0;
                    resp_status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RX: begin
                rx_sh_d = {rx_sh_q[45:0], cmd_i};
                if (cnt_q < CNT_W'(CRC_BITS)) begin
                    crc_d = crc7_step(crc_q, cmd_i);
                end
                if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                    state_d    = S_DONE;
                    resp_cmd_d = rx_sh_d[45:40];
                    resp_arg_d = rx_sh_d[39:8];
                    if (rx_sh_d[46] || !rx_sh_d[0]) begin
                        resp_status_d = ST_FRAME;
                    end else if (rx_sh_d[7:1] != crc_q) begin
                        resp_status_d = ST_CRC;
                    end else begin
                        resp_status_d = ST_OK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_sdio_host_cmd.sv
// Scoreboard bench for sdio_host_cmd: drivers push expected TX frames and
// responses; independent monitors capture the CMD line and resp_valid.
module tb_sdio_host_cmd;

    localparam int unsigned PRE = 16;
    localparam int unsigned TMO = 64;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [1:0]  status;
        logic        chk_lat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_cmd;
    logic [31:0] req_arg;
    logic        cmd_o;
    logic        cmd_oe;
    logic        cmd_i;
    logic        resp_valid;
    logic [5:0]  resp_cmd;
    logic [31:0] resp_arg;
    logic [1:0]  resp_status;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rel_cyc = 0;
    int resp_seen = 0;
    logic in_abort  = 1'b0;
    logic dev_reply = 1'b0;
    logic [47:0] dev_frame = '0;
    logic prev_oe = 1'b0;

    logic [47:0] exp_tx[$];
    resp_t       exp_resp[$];

    sdio_host_cmd #(.PREAMBLE(PRE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_arg(req_arg),
        .cmd_o(cmd_o), .cmd_oe(cmd_oe), .cmd_i(cmd_i),
        .resp_valid(resp_valid), .resp_cmd(resp_cmd),
        .resp_arg(resp_arg), .resp_status(resp_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TX monitor: capture preamble + frame while the host drives the line
    always begin
        int n;
        logic pre_ok;
        logic [47:0] frame;
        @(negedge clk);
        if (cmd_oe) begin
            n = 0;
            pre_ok = 1'b1;
            frame = '0;
            while (cmd_oe && n < 100) begin
                if (n < int'(PRE)) begin
                    if (!cmd_o) pre_ok = 1'b0;
                end else begin
                    frame = {frame[46:0], cmd_o};
                end
                n++;
                @(negedge clk);
            end
            rel_cyc = cyc;
            if (!in_abort) begin
                chk("tx_len", 64'(n), 64'(PRE + 48));
                chk("tx_preamble", 64'(pre_ok), 64'(1));
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected", 64'(1), 64'(0));
                end else begin
                    chk("tx_frame", 64'(frame), 64'(exp_tx.pop_front()));
                end
            end
        end
    end

    // Response monitor: compare each resp_valid pulse against the scoreboard
    always begin
        resp_t e;
        @(negedge clk);
        if (resp_valid) begin
            resp_seen++;
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected", 64'(1), 64'(0));
            end else begin
                e = exp_resp.pop_front();
                chk("resp_cmd", 64'(resp_cmd), 64'(e.cmd));
                chk("resp_arg", 64'(resp_arg), 64'(e.arg));
                chk("resp_status", 64'(resp_status), 64'(e.status));
                if (e.chk_lat) chk("timeout_latency", 64'(cyc - rel_cyc), 64'(TMO));
                @(negedge clk);
                chk("resp_pulse_width", 64'(resp_valid), 64'(0));
                chk("resp_hold", 64'({resp_cmd, resp_arg, resp_status}),
                    64'({e.cmd, e.arg, e.status}));
                chk("ready_after_resp", 64'(req_ready), 64'(1));
            end
        end
    end

    // Device model: after release, 2 idle-high cycles then the reply frame
    always begin
        logic [47:0] f;
        @(negedge clk);
        if (prev_oe && !cmd_oe && dev_reply) begin
            f = dev_frame;
            @(negedge clk);
            @(negedge clk);
            for (int i = 47; i >= 0; i--) begin
                cmd_i = f[i];
                @(negedge clk);
            end
            cmd_i = 1'b1;
        end
        prev_oe = cmd_oe;
    end

    task automatic issue(input logic [5:0] c, input logic [31:0] a);
        logic done;
        done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = c;
        req_arg   = a;
        for (int i = 0; i < 300 && !done; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            req_valid = 1'b0;
            chk("handshake_timeout", 64'(0), 64'(1));
        end
    endtask

    task automatic run(input logic [5:0] c, input logic [31:0] a, input logic [47:0] tx,
                       input logic reply, input logic [47:0] rframe,
                       input logic [5:0] ec, input logic [31:0] ea,
                       input logic [1:0] es, input logic lat);
        logic got;
        resp_t e;
        got = 1'b0;
        dev_reply = reply;
        dev_frame = rframe;
        e.cmd = ec; e.arg = ea; e.status = es; e.chk_lat = lat;
        exp_tx.push_back(tx);
        exp_resp.push_back(e);
        issue(c, a);
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        chk("resp_arrived", 64'(got), 64'(1));
    endtask

    localparam logic [47:0] TX_3F   = 48'h7FF0000F0F0B;
    localparam logic [47:0] TX_00   = 48'h400000000095;
    localparam logic [47:0] RSP_OK  = 48'h3FF00FF00FFB;
    localparam logic [47:0] RSP_CRC = 48'h3FF00FF00FFD;
    localparam logic [47:0] RSP_FRM = 48'h3FF00FF00FFA;

    initial begin
        int ready_cnt;
        int resp_cnt;
        int seen0;
        resp_t e;

        rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_arg = '0; cmd_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_cmd_oe", 64'(cmd_oe), 64'(0));
        chk("rst_cmd_o", 64'(cmd_o), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_cmd", 64'(resp_cmd), 64'(0));
        chk("rst_resp_arg", 64'(resp_arg), 64'(0));
        chk("rst_resp_status", 64'(resp_status), 64'(0));
        rst_n = 1'b1;

        // Nominal command and reply
        run(6'h3F, 32'hF0000F0F, TX_3F, 1'b1, RSP_OK, 6'h3F, 32'hF00FF00F, 2'd0, 1'b0);
        // CMD0 frame
        run(6'h00, 32'h0, TX_00, 1'b1, RSP_OK, 6'h3F, 32'hF00FF00F, 2'd0, 1'b0);

        // Timeout; previous response must hold while this one is in flight
        dev_reply = 1'b0;
        e.cmd = 6'h0; e.arg = 32'h0; e.status = 2'd2; e.chk_lat = 1'b1;
        exp_tx.push_back(TX_3F);
        exp_resp.push_back(e);
        issue(6'h3F, 32'hF0000F0F);
        repeat (30) @(negedge clk);
        chk("resp_held_cmd", 64'(resp_cmd), 64'(6'h3F));
        chk("resp_held_arg", 64'(resp_arg), 64'(32'hF00FF00F));
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                if (resp_valid) got = 1'b1;
            end
            chk("timeout_resp_arrived", 64'(got), 64'(1));
        end

        // CRC error, then framing error (end bit 0, CRC also intact)
        run(6'h3F, 32'hF0000F0F, TX_3F, 1'b1, RSP_CRC, 6'h3F, 32'hF00FF00F, 2'd1, 1'b0);
        run(6'h3F, 32'hF0000F0F, TX_3F, 1'b1, RSP_FRM, 6'h3F, 32'hF00FF00F, 2'd3, 1'b0);

        // req_valid held high: one command per transaction, ready only in IDLE
        dev_reply = 1'b1;
        dev_frame = RSP_OK;
        e.cmd = 6'h3F; e.arg = 32'hF00FF00F; e.status = 2'd0; e.chk_lat = 1'b0;
        exp_tx.push_back(TX_3F);  exp_tx.push_back(TX_3F);
        exp_resp.push_back(e);    exp_resp.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 6'h3F; req_arg = 32'hF0000F0F;
        ready_cnt = 0; resp_cnt = 0;
        for (int i = 0; i < 600 && resp_cnt < 2; i++) begin
            if (req_ready) ready_cnt++;
            if (resp_valid) resp_cnt++;
            if (resp_cnt < 2) @(negedge clk);
        end
        req_valid = 1'b0;
        chk("held_valid_resps", 64'(resp_cnt), 64'(2));
        chk("held_valid_ready_cycles", 64'(ready_cnt), 64'(2));
        repeat (3) @(negedge clk);

        // Reset during TX bit 20: immediate release, no response, then recovery
        dev_reply = 1'b0;
        in_abort  = 1'b1;
        seen0 = resp_seen;
        issue(6'h11, 32'h12345678);
        repeat (36) @(posedge clk);
        #2;
        chk("abort_driving_before", 64'(cmd_oe), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_cmd_oe", 64'(cmd_oe), 64'(0));
        chk("abort_cmd_o", 64'(cmd_o), 64'(1));
        chk("abort_req_ready", 64'(req_ready), 64'(1));
        chk("abort_resp_cmd_clr", 64'(resp_cmd), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("abort_no_resp", 64'(resp_seen - seen0), 64'(0));
        in_abort = 1'b0;
        run(6'h00, 32'h0, TX_00, 1'b1, RSP_OK, 6'h3F, 32'hF00FF00F, 2'd0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_tx_empty", 64'(exp_tx.size()), 64'(0));
        chk("scoreboard_resp_empty", 64'(exp_resp.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
